// File: rtl/dpram_pkg.sv
// Shared constants and state encoding for the dual-port RAM stream reader.
package dpram_pkg;

  localparam int MEM_WORDS    = 1472;
  localparam int ADDR_W       = 11;
  localparam int READ_LATENCY = 2;
  localparam int FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide.
module stream_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset because its head entry drives the stream outputs, which must read 0 in reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst read controller for the dual-port RAM port B: issues credit-limited reads,
// realigns the 2-cycle RAM latency and streams the words out with last marking.
module dpram_stream_reader
  import dpram_pkg::*;
#(
  parameter int dataWidth    = 32,
  parameter int memblocksize = 47104,
  parameter int addressWidth = $clog2(memblocksize / dataWidth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addressWidth-1:0] base_addr,
  input  logic [addressWidth:0]   length,
  output logic                    busy,
  output logic                    done,
  output logic                    enableB,
  output logic [addressWidth-1:0] addressB,
  input  logic [dataWidth-1:0]    dataoutB,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [dataWidth-1:0]    m_data,
  output logic                    m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(MEM_WORDS - 1);
  localparam logic [addressWidth-1:0] WRAP_SPAN = addressWidth'(MEM_WORDS);

  state_e                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic [addressWidth:0]   len_q, len_d;
  logic [addressWidth:0]   issued_q, issued_d;
  logic                    done_q, done_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_last_q;

  logic                    issue, issue_last, credit_ok, pop;
  logic [CNT_W-1:0]        fifo_count;
  logic [dataWidth:0]      fifo_rdata;

  // Reads in flight plus words held in the FIFO may never exceed its depth.
  assign credit_ok  = (int'(fifo_count) + $countones(pipe_vld_q)) < FIFO_DEPTH;
  assign issue_last = (issued_q == len_q - (addressWidth + 1)'(1));
  assign m_valid    = (fifo_count != '0);
  assign pop        = m_valid && m_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = (base_addr >= WRAP_SPAN) ? base_addr - WRAP_SPAN : base_addr;
            len_d    = length;
            issued_d = '0;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue    = 1'b1;
          addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + addressWidth'(1);
          issued_d = issued_q + (addressWidth + 1)'(1);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      pipe_vld_q  <= {pipe_vld_q[READ_LATENCY-2:0], issue};
      pipe_last_q <= {pipe_last_q[READ_LATENCY-2:0], issue && issue_last};
    end
  end

  stream_fifo #(
    .WIDTH (dataWidth + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (pipe_vld_q[READ_LATENCY-1]),
    .wdata_i ({pipe_last_q[READ_LATENCY-1], dataoutB}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign enableB  = issue;
  assign addressB = addr_q;
  assign m_data   = fifo_rdata[dataWidth-1:0];
  assign m_last   = fifo_rdata[dataWidth];

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Scoreboard bench for dpram_stream_reader with a 2-cycle-latency RAM model (word k holds k).
module tb_dpram_stream_reader;
  import dpram_pkg::*;

  localparam int DW = 32;
  localparam int AW = ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          m_ready = 1'b0;
  logic          busy, done, enableB, m_valid, m_last;
  logic [AW-1:0] addressB;
  logic [DW-1:0] dataoutB, m_data;
  logic [DW-1:0] ram_s1 = '0, ram_s2 = '0;

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb[$];

  int   cyc = 0, start_cyc = 0, cur_base = 0;
  int   n_reads = 0, n_hs = 0, outstanding = 0;
  int   first_en = -1, first_addr = -1, first_valid = -1, last_hs = -1, done_cyc = -1;
  bit   mon_en = 1'b0, stall_prev = 1'b0;
  logic [DW:0] held = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (enableB) ram_s1 <= DW'(addressB);
    ram_s2 <= ram_s1;
  end
  assign dataoutB = ram_s2;

  dpram_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .enableB   (enableB),
    .addressB  (addressB),
    .dataoutB  (dataoutB),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int rel;
    logic [DW:0] exp_w;
    if (mon_en) begin
      rel = cyc - start_cyc;
      if (enableB) begin
        check("rd_addr", 64'(addressB), 64'((cur_base + n_reads) % MEM_WORDS));
        check("rd_credit", 64'(outstanding < FIFO_DEPTH), 64'd1);
        if (first_en < 0) begin
          first_en   = rel;
          first_addr = int'(addressB);
        end
        n_reads++;
        outstanding++;
      end
      if (stall_prev) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_word", 64'({m_last, m_data}), 64'(held));
      end
      if (m_valid && first_valid < 0) first_valid = rel;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          exp_w = sb.pop_front();
          check("stream_word", 64'({m_last, m_data}), 64'(exp_w));
        end
        if (m_last) last_hs = rel;
        n_hs++;
        outstanding--;
      end
      stall_prev = m_valid && !m_ready;
      held       = {m_last, m_data};
      if (done && rel > 0 && done_cyc < 0) begin
        done_cyc = rel;
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic new_burst(input int b, input int len);
    start       = 1'b1;
    base_addr   = AW'(b);
    length      = (AW + 1)'(len);
    start_cyc   = cyc;
    cur_base    = b;
    n_reads     = 0;
    n_hs        = 0;
    first_en    = -1;
    first_addr  = -1;
    first_valid = -1;
    last_hs     = -1;
    done_cyc    = -1;
    for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), DW'((b + i) % MEM_WORDS)});
  endtask

  task automatic run_start(input int b, input int len);
    @(posedge clk); #1;
    new_burst(b, len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      m_ready = bp ? ((i % 4) == 0 || (i % 4) == 3) : 1'b1;
      @(negedge clk);
      if (done_cyc >= 0) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(busy),     64'd0);
    check({tag, "_done"},  64'(done),     64'd0);
    check({tag, "_en"},    64'(enableB),  64'd0);
    check({tag, "_addr"},  64'(addressB), 64'd0);
    check({tag, "_valid"}, 64'(m_valid),  64'd0);
    check({tag, "_data"},  64'(m_data),   64'd0);
    check({tag, "_last"},  64'(m_last),   64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst     = 1'b1;
    m_ready = 1'b1;
    mon_en  = 1'b1;

    // Single burst at full rate
    run_start(10, 5);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(40, 1'b0);
    check("t1_first_en",    64'(first_en),    64'd1);
    check("t1_first_addr",  64'(first_addr),  64'd10);
    check("t1_first_valid", 64'(first_valid), 64'd4);
    check("t1_last_hs",     64'(last_hs),     64'd8);
    check("t1_done_cyc",    64'(done_cyc),    64'd9);
    check("t1_words",       64'(n_hs),        64'd5);
    check("t1_sb_empty",    64'(sb.size()),   64'd0);

    // Address wrap
    run_start(1470, 4);
    wait_done(40, 1'b0);
    check("t2_reads",    64'(n_reads),   64'd4);
    check("t2_words",    64'(n_hs),      64'd4);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure with ready pattern 1,0,0,1
    run_start(700, 16);
    wait_done(200, 1'b1);
    check("t3_words",    64'(n_hs),      64'd16);
    check("t3_reads",    64'(n_reads),   64'd16);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Zero length
    run_start(5, 0);
    wait_done(10, 1'b0);
    check("t4_done_cyc", 64'(done_cyc), 64'd1);
    check("t4_reads",    64'(n_reads),  64'd0);

    // Start pulsed mid-burst is ignored
    run_start(300, 8);
    repeat (2) begin
      @(posedge clk); #1;
    end
    start     = 1'b1;
    base_addr = AW'(500);
    length    = (AW + 1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, 1'b0);
    repeat (4) @(negedge clk);
    check("t4b_words",    64'(n_hs),      64'd8);
    check("t4b_reads",    64'(n_reads),   64'd8);
    check("t4b_sb_empty", 64'(sb.size()), 64'd0);
    check("t4b_valid",    64'(m_valid),   64'd0);
    check("t4b_busy",     64'(busy),      64'd0);

    // Reset in cycle 6 of a 20-word burst
    run_start(40, 20);
    repeat (5) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    outstanding = 0;
    stall_prev  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_valid", 64'(m_valid), 64'd0);
    end
    mon_en = 1'b1;
    run_start(0, 2);
    wait_done(40, 1'b0);
    check("t5_words",    64'(n_hs),      64'd2);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back: second start in the done cycle
    run_start(100, 3);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("t6_done_cycle", 64'(done), 64'd1);
    check("t6_busy_low",   64'(busy), 64'd0);
    new_burst(200, 3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, 1'b0);
    check("t6_first_valid", 64'(first_valid), 64'd4);
    check("t6_words",       64'(n_hs),        64'd3);
    check("t6_sb_empty",    64'(sb.size()),   64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
# dpram_stream_reader

Read-side controller for the simple dual-port weight/activation RAM. It accepts a burst command of base address and word count and drives the RAM read port (enable and address). It absorbs the RAM's fixed 2-cycle read latency and presents the words in address order on a valid/ready stream with `last` marking. It sits between a `dpram` instance's port B and the downstream PE-array loader, with full throughput and lossless backpressure.

## Interface
- `dataWidth`, 32, word width; must equal the RAM `dataWidth`.
- `memblocksize`, 47104, RAM size in bits.
- `addressWidth`, `$clog2(memblocksize/dataWidth)` (11), RAM word-address width.
- `clk` in 1: single clock, shared with the RAM.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: burst request; accepted only in IDLE.
- `base_addr` in addressWidth: first word address; sampled with an accepted `start`.
- `length` in addressWidth+1: word count; sampled with an accepted `start`.
- `busy` out 1: high from accept until `done`.
- `done` out 1: one-cycle completion pulse.
- `enableB` out 1: RAM read enable; connects to the RAM `enableB`.
- `addressB` out addressWidth: RAM read address.
- `dataoutB` in dataWidth: RAM read data, valid 2 cycles after `enableB`.
- `m_valid` out 1: stream data valid.
- `m_ready` in 1: downstream ready.
- `m_data` out dataWidth: stream data.
- `m_last` out 1: final word of the burst.

## Operation
- **States:**
  - IDLE: `start` with `length`≠0 latches the address and count, then goes to ISSUE. `start` with `length`=0 pulses `done` next cycle with no reads.
  - ISSUE: issues one read per cycle while credit is available. Moves to DRAIN after the last read is issued.
  - DRAIN: waits for the `m_last` handshake, pulses `done`, and returns to IDLE.
- **Credit rule:**
  - Issue only when in-flight + FIFO count < 4.
  - A pop frees its credit the cycle after the pop.
  - Guarantees the FIFO never overflows.
- **In-flight tracking:** a 2-stage valid shift register aligned to RAM latency. Its stage-2 output writes `dataoutB` into the FIFO, tagged with last = (issue index == `length`−1).
- **Addressing:** `addressB` = base + i, modulo MEM_WORDS (1472). The address wraps to 0 after 1471, and never emits a value ≥1472.
- **Ignored `start`:** `start` while `busy` is ignored. No queuing, no error.
- **Backpressure:** `m_data` and `m_last` hold stable while `m_valid` && !`m_ready`. `m_valid` never drops without a handshake.
- **Simultaneous FIFO push and pop:** allowed; the count is unchanged.
- **Reset (including mid-burst):**
  - Asynchronously returns to IDLE and clears the FIFO, in-flight pipe and counters.
  - All outputs go to 0: `busy`, `done`, `enableB`, `addressB`, `m_valid`, `m_data`, `m_last`.
  - RAM data returning after reset is discarded, because the in-flight pipe is cleared.

## Timing
- `start` accepted in cycle 0 gives:
  - first `enableB` in cycle 1 with `addressB`=base;
  - `dataoutB` valid in cycle 3;
  - FIFO write at the end of cycle 3;
  - `m_valid` in cycle 4.
- With `m_ready` held high, N words stream on N consecutive cycles, cycles 4…N+3.
- `done` is high in the cycle after the `m_last` handshake. `busy` drops in that same cycle.
- The earliest next `start` is accepted in the cycle `done` is high. That `done` cycle counts as IDLE.
- With `m_ready` low indefinitely, at most 4 reads are outstanding and `enableB` stays low until a pop.
- `enableB` is low in every cycle in which no read is issued. `addressB` is don't-care when `enableB` is low.

## Structure
- `dpram_pkg` holds:
  - MEM_WORDS = 1472 and ADDR_W = 11;
  - READ_LATENCY = 2 and FIFO_DEPTH = 4;
  - the state enum {IDLE, ISSUE, DRAIN}.
- One sub-module: `stream_fifo`, a synchronous FIFO, 4 deep, width dataWidth+1 (data plus last). It provides registered outputs, count, and simultaneous push/pop. The reader instantiates it once.
- Counters in the top level: issue count, address, and in-flight pipe.

## Test plan
- **Single burst at full rate:** RAM preloaded with word k = k; base=10, length=5, `m_ready`=1.
  - Expect `m_data` 10..14 in cycles 4..8, `m_last` in cycle 8, `done` in cycle 9.
- **Address wrap:** base=1470, length=4.
  - Expect reads at 1470, 1471, 0, 1, and stream 1470, 1471, 0, 1.
- **Backpressure:** length=16, `m_ready` pattern 1,0,0,1 repeated.
  - Expect all 16 words in order, none lost or duplicated, `enableB` never with 4 outstanding.
  - Expect `m_data` stable while stalled.
- **Zero length and ignored start:** `start` with length=0.
  - Expect `done` in cycle 1, no `enableB`.
  - A `start` pulsed mid-burst has no effect on the stream or the count.
- **Reset mid-burst:** assert `rst` low in cycle 6 of a 20-word burst.
  - Expect all outputs 0 immediately and `m_valid` 0 after release.
  - A new burst with base=0, length=2 returns 0 and 1 only.
- **Back-to-back bursts:** second `start` in the `done` cycle.
  - Expect the second burst's first `m_valid` exactly 4 cycles later.
